// File: rtl/one_hot_encoder_pipe.sv
// one_hot_encoder_pipe: one-hot to binary encoder with 2-entry skid buffer and error statistics
module one_hot_encoder_pipe #(
  parameter int one_hot_word = 16,
  parameter int binary_word  = 4,
  parameter int err_cnt_word = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [one_hot_word-1:0] one_hot_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [binary_word-1:0]  bin_o,
  output logic                    err_o,
  output logic                    err_sticky_o,
  output logic [err_cnt_word-1:0] err_cnt_o,
  input  logic                    clr_err_i
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t                 state;
  logic [binary_word-1:0] enc_bin;
  logic                   enc_err;
  logic [binary_word-1:0] nxt_bin;
  logic                   nxt_err;
  logic                   accept;
  logic                   consume;
  logic                   acc_err;
  assign accept  = in_valid_i & in_ready_o;
  assign consume = out_valid_o & out_ready_i;
  assign acc_err = accept & enc_err;
  assign enc_err = (one_hot_i == '0) || ((one_hot_i & (one_hot_i - one_hot_word'(1))) != '0);
  always_comb begin
    enc_bin = '0;
    for (int i = one_hot_word - 1; i >= 0; i--)
      enc_bin = one_hot_i[i] ? binary_word'(i) : enc_bin;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      bin_o       <= '0;
      err_o       <= 1'b0;
      nxt_bin     <= '0;
      nxt_err     <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state       <= ONE;
          out_valid_o <= 1'b1;
          bin_o       <= enc_bin;
          err_o       <= enc_err;
        end
        ONE: if (accept && consume) begin
          bin_o <= enc_bin;
          err_o <= enc_err;
        end else if (accept) begin
          state      <= TWO;
          in_ready_o <= 1'b0;
          nxt_bin    <= enc_bin;
          nxt_err    <= enc_err;
        end else if (consume) begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
        end
        TWO: if (consume) begin
          state      <= ONE;
          in_ready_o <= 1'b1;
          bin_o      <= nxt_bin;
          err_o      <= nxt_err;
        end
        default: begin
          state       <= EMPTY;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o    <= '0;
      err_sticky_o <= 1'b0;
    end else begin
      err_cnt_o    <= clr_err_i ? err_cnt_word'(acc_err) :
                      (acc_err && !(&err_cnt_o)) ? err_cnt_o + err_cnt_word'(1) : err_cnt_o;
      err_sticky_o <= acc_err | (err_sticky_o & ~clr_err_i);
    end
  end
endmodule

// File: tb/tb_one_hot_encoder_pipe.sv
// tb_one_hot_encoder_pipe: scoreboard bench for one_hot_encoder_pipe
module tb_one_hot_encoder_pipe;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] one_hot_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [3:0]  bin_o;
  logic        err_o;
  logic        err_sticky_o;
  logic [7:0]  err_cnt_o;
  logic        clr_err_i = 1'b0;
  int          n_checks = 0;
  int          n_fails = 0;
  logic [4:0]  sb[$];

  one_hot_encoder_pipe #(.one_hot_word(16), .binary_word(4), .err_cnt_word(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .one_hot_i(one_hot_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .bin_o(bin_o), .err_o(err_o), .err_sticky_o(err_sticky_o), .err_cnt_o(err_cnt_o),
    .clr_err_i(clr_err_i)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model(input logic [15:0] d);
    logic [3:0] b = '0;
    for (int i = 15; i >= 0; i--) if (d[i]) b = 4'(i);
    return {b, $countones(d) != 1};
  endfunction

  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      logic [4:0] e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL beat_unexpected: got bin=%0d err=%0b, required no beat", bin_o, err_o);
      end else begin
        e = sb.pop_front();
        if ({bin_o, err_o} !== e) begin
          n_fails++;
          $display("FAIL beat: got bin=%0d err=%0b, required bin=%0d err=%0b", bin_o, err_o, e[4:1], e[0]);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [15:0] d);
    in_valid_i = v;
    one_hot_i  = d;
    @(negedge clk);
    if (v && in_ready_o && !rst_i) sb.push_back(model(d));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(1'b1, 16'h0001);
    step(1'b1, 16'h0002);
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    n_checks += 6;
    if (out_valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid_o); end
    if (in_ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready_o); end
    if (bin_o !== 4'd0) begin n_fails++; $display("FAIL reset_bin: got %0d, required 0", bin_o); end
    if (err_o !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b, required 0", err_o); end
    if (err_sticky_o !== 1'b0) begin n_fails++; $display("FAIL reset_sticky: got %b, required 0", err_sticky_o); end
    if (err_cnt_o !== 8'd0) begin n_fails++; $display("FAIL reset_cnt: got %0d, required 0", err_cnt_o); end
  endtask

  task automatic test_stream();
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'h0001 << i);
      n_checks += 2;
      if (out_valid_o !== 1'b1) begin n_fails++; $display("FAIL stream_valid[%0d]: got %b, required 1", i, out_valid_o); end
      if (in_ready_o !== 1'b1) begin n_fails++; $display("FAIL stream_ready[%0d]: got %b, required 1", i, in_ready_o); end
    end
    step(1'b0, '0);
    step(1'b0, '0);
    n_checks += 2;
    if (out_valid_o !== 1'b0) begin n_fails++; $display("FAIL stream_idle: got out_valid %b, required 0", out_valid_o); end
    if (sb.size() != 0) begin n_fails++; $display("FAIL stream_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int budget = 0;
    out_ready_i = 1'b0;
    step(1'b1, 16'h0010);
    n_checks++;
    if (in_ready_o !== 1'b1) begin n_fails++; $display("FAIL bp_ready1: got %b, required 1", in_ready_o); end
    step(1'b1, 16'h0400);
    n_checks += 2;
    if (in_ready_o !== 1'b0) begin n_fails++; $display("FAIL bp_ready2: got %b, required 0", in_ready_o); end
    if (bin_o !== 4'd4) begin n_fails++; $display("FAIL bp_head: got %0d, required 4", bin_o); end
    step(1'b1, 16'h0001);
    n_checks += 4;
    if (sb.size() != 2) begin n_fails++; $display("FAIL bp_accepts: got %0d, required 2", sb.size()); end
    if (in_ready_o !== 1'b0) begin n_fails++; $display("FAIL bp_ready3: got %b, required 0", in_ready_o); end
    if (out_valid_o !== 1'b1) begin n_fails++; $display("FAIL bp_valid: got %b, required 1", out_valid_o); end
    if ({bin_o, err_o} !== 5'b0100_0) begin n_fails++; $display("FAIL bp_stable: got bin=%0d err=%b, required bin=4 err=0", bin_o, err_o); end
    out_ready_i = 1'b1;
    while (sb.size() < 3 && budget < 10) begin
      step(1'b1, 16'h0001);
      budget++;
    end
    while ((sb.size() != 0 || out_valid_o) && budget < 20) begin
      step(1'b0, '0);
      budget++;
    end
    n_checks++;
    if (budget >= 20 || sb.size() != 0) begin n_fails++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_errors();
    out_ready_i = 1'b1;
    step(1'b1, 16'h0000);
    n_checks++;
    if ({bin_o, err_o} !== 5'b0000_1) begin n_fails++; $display("FAIL err_zero: got bin=%0d err=%b, required bin=0 err=1", bin_o, err_o); end
    step(1'b1, 16'h0006);
    n_checks++;
    if ({bin_o, err_o} !== 5'b0001_1) begin n_fails++; $display("FAIL err_multi: got bin=%0d err=%b, required bin=1 err=1", bin_o, err_o); end
    step(1'b0, '0);
    n_checks += 2;
    if (err_cnt_o !== 8'd2) begin n_fails++; $display("FAIL err_cnt: got %0d, required 2", err_cnt_o); end
    if (err_sticky_o !== 1'b1) begin n_fails++; $display("FAIL err_sticky: got %b, required 1", err_sticky_o); end
  endtask

  task automatic test_saturation();
    out_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) step(1'b1, 16'h0000);
    step(1'b0, '0);
    n_checks++;
    if (err_cnt_o !== 8'd255) begin n_fails++; $display("FAIL sat_cnt: got %0d, required 255", err_cnt_o); end
    clr_err_i = 1'b1;
    step(1'b1, 16'h0003);
    clr_err_i = 1'b0;
    n_checks += 2;
    if (err_cnt_o !== 8'd1) begin n_fails++; $display("FAIL clr_with_err_cnt: got %0d, required 1", err_cnt_o); end
    if (err_sticky_o !== 1'b1) begin n_fails++; $display("FAIL clr_with_err_sticky: got %b, required 1", err_sticky_o); end
    clr_err_i = 1'b1;
    step(1'b0, '0);
    clr_err_i = 1'b0;
    n_checks += 2;
    if (err_cnt_o !== 8'd0) begin n_fails++; $display("FAIL clr_cnt: got %0d, required 0", err_cnt_o); end
    if (err_sticky_o !== 1'b0) begin n_fails++; $display("FAIL clr_sticky: got %b, required 0", err_sticky_o); end
    out_ready_i = 1'b0;
    step(1'b1, 16'h0000);
    step(1'b1, 16'h00ff);
    step(1'b0, '0);
    n_checks++;
    if (err_cnt_o !== 8'd2) begin n_fails++; $display("FAIL bp_err_cnt: got %0d, required 2", err_cnt_o); end
  endtask

  task automatic test_reset_mid();
    n_checks++;
    if (in_ready_o !== 1'b0) begin n_fails++; $display("FAIL mid_full: got in_ready %b, required 0", in_ready_o); end
    rst_i = 1'b1;
    step(1'b1, 16'h0008);
    rst_i = 1'b0;
    sb.delete();
    n_checks += 4;
    if (out_valid_o !== 1'b0) begin n_fails++; $display("FAIL mid_valid: got %b, required 0", out_valid_o); end
    if (in_ready_o !== 1'b1) begin n_fails++; $display("FAIL mid_ready: got %b, required 1", in_ready_o); end
    if (err_cnt_o !== 8'd0) begin n_fails++; $display("FAIL mid_cnt: got %0d, required 0", err_cnt_o); end
    if (err_sticky_o !== 1'b0) begin n_fails++; $display("FAIL mid_sticky: got %b, required 0", err_sticky_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    step(1'b1, 16'h0020);
    n_checks++;
    if ({bin_o, err_o} !== 5'b0101_0) begin n_fails++; $display("FAIL mid_after: got bin=%0d err=%b, required bin=5 err=0", bin_o, err_o); end
    step(1'b0, '0);
    step(1'b0, '0);
    n_checks++;
    if (sb.size() != 0 || out_valid_o !== 1'b0) begin n_fails++; $display("FAIL mid_drain: got %0d pending valid=%b, required 0", sb.size(), out_valid_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_errors();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
